regarray_step_ctrl: RTL and testbench

- Initiator-side controller that drives the register-array/ALU datapath (RegATop) through its operand-read, flag-update and write-back phases.
- Holds a small loadable micro-program of register operations. On each step (debounced button or auto timer) it fetches one entry, presents its addresses, ALU_OP and Reg_Write, then issues the clk_RR, clk_F and clk_WB phase pulses in order.
- Sits between the board buttons/switches and RegATop on the FPGA top level.

---
 rtl/regarray_pkg.sv | 50 +++++
 rtl/btn_debounce.sv | 46 ++++
 rtl/regarray_step_ctrl.sv | 154 +++++++++++++++
 tb/tb_regarray_step_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regarray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regarray_pkg
// Purpose  : Shared entry layout, ALU_OP codes and step-FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package regarray_pkg;

  localparam int ENTRY_W = 20;
  localparam int ADDR_W  = 5;
  localparam int OP_W    = 4;

  localparam int A_LSB  = 0;
  localparam int B_LSB  = 5;
  localparam int W_LSB  = 10;
  localparam int OP_LSB = 15;
  localparam int RW_BIT = 19;

  // Field order matches the bit positions above, MSB first.
  typedef struct packed {
    logic              reg_write;
    logic [OP_W-1:0]   alu_op;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr_b;
    logic [ADDR_W-1:0] r_addr_a;
  } entry_t;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [OP_W-1:0] ALU_AND  = 4'h2;
  localparam logic [OP_W-1:0] ALU_OR   = 4'h3;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'h4;
  localparam logic [OP_W-1:0] ALU_NOT  = 4'h5;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'h6;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'h7;
  localparam logic [OP_W-1:0] ALU_PASS = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_RR_H  = 3'd2,
    ST_RR_L  = 3'd3,
    ST_F_H   = 3'd4,
    ST_F_L   = 3'd5,
    ST_WB_H  = 3'd6,
    ST_WB_L  = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : Button synchroniser + stability filter, one-cycle rising pulse.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DB_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam int c_cnt_w = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYC - 1);

  logic [1:0]         r_sync;
  logic               r_level;
  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      rise    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], btn};
      rise   <= 1'b0;
      // Any sample agreeing with the current level restarts the run.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
        rise    <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regarray_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regarray_step_ctrl
// Purpose  : Steps a micro-program through RegATop's RR / F / WB phases.
// Revision : 1.0 - initial release
// ============================================================================
module regarray_step_ctrl
  import regarray_pkg::*;
#(
  parameter int PROG_DEPTH = 8,
  parameter int PC_W       = 3,
  parameter int DB_CYC     = 500000,
  parameter int AUTO_DIV   = 50000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               step_btn,
  input  logic               auto_mode,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [ENTRY_W-1:0] prog_data,
  output logic [ADDR_W-1:0]  R_Addr_A,
  output logic [ADDR_W-1:0]  R_Addr_B,
  output logic [ADDR_W-1:0]  W_Addr,
  output logic [OP_W-1:0]    ALU_OP,
  output logic               Reg_Write,
  output logic               clk_RR,
  output logic               clk_F,
  output logic               clk_WB,
  output logic               busy,
  output logic [PC_W-1:0]    pc
);

  localparam int c_auto_w = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [c_auto_w-1:0] c_auto_last = c_auto_w'(AUTO_DIV - 1);

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  logic                w_btn_rise;
  logic                r_auto_mode;
  logic [c_auto_w-1:0] r_auto_cnt;
  logic                r_auto_tick;
  logic                w_req;
  logic                r_pending;
  state_t              r_state;
  entry_t              r_mem [PROG_DEPTH];

  // Assertion is immediate; release waits two clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end
  assign w_rst_n = r_rst_sync[1];

  btn_debounce #(
    .DB_CYC (DB_CYC)
  ) u_btn_debounce (
    .clk   (clk),
    .rst_n (w_rst_n),
    .btn   (step_btn),
    .rise  (w_btn_rise)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_auto_mode <= 1'b0;
      r_auto_cnt  <= '0;
      r_auto_tick <= 1'b0;
    end else begin
      r_auto_mode <= auto_mode;
      r_auto_tick <= 1'b0;
      if (auto_mode != r_auto_mode || !r_auto_mode) begin
        r_auto_cnt <= '0;
      end else if (r_auto_cnt == c_auto_last) begin
        r_auto_cnt  <= '0;
        r_auto_tick <= 1'b1;
      end else begin
        r_auto_cnt <= r_auto_cnt + c_auto_w'(1);
      end
    end
  end

  assign w_req = r_auto_mode ? r_auto_tick : w_btn_rise;

  // Program store is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= entry_t'(prog_data);
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= ST_IDLE;
      r_pending <= 1'b0;
      R_Addr_A  <= '0;
      R_Addr_B  <= '0;
      W_Addr    <= '0;
      ALU_OP    <= '0;
      Reg_Write <= 1'b0;
      clk_RR    <= 1'b0;
      clk_F     <= 1'b0;
      clk_WB    <= 1'b0;
      busy      <= 1'b0;
      pc        <= '0;
    end else begin
      clk_RR <= 1'b0;
      clk_F  <= 1'b0;
      clk_WB <= 1'b0;
      if (w_req && r_state != ST_IDLE) begin
        r_pending <= 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_req || r_pending) begin
            r_state   <= ST_FETCH;
            r_pending <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_FETCH: begin
          R_Addr_A  <= r_mem[pc].r_addr_a;
          R_Addr_B  <= r_mem[pc].r_addr_b;
          W_Addr    <= r_mem[pc].w_addr;
          ALU_OP    <= r_mem[pc].alu_op;
          Reg_Write <= r_mem[pc].reg_write;
          clk_RR    <= 1'b1;
          r_state   <= ST_RR_H;
        end
        ST_RR_H: r_state <= ST_RR_L;
        ST_RR_L: begin
          clk_F   <= 1'b1;
          r_state <= ST_F_H;
        end
        ST_F_H: r_state <= ST_F_L;
        ST_F_L: begin
          clk_WB  <= 1'b1;
          r_state <= ST_WB_H;
        end
        ST_WB_H: r_state <= ST_WB_L;
        ST_WB_L: begin
          pc      <= pc + PC_W'(1);
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regarray_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regarray_step_ctrl
// Purpose  : Randomised self-checking bench against a sequence-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regarray_step_ctrl;

  localparam int PROG_DEPTH = 8;
  localparam int PC_W       = 3;
  localparam int DB_CYC     = 4;
  localparam int AUTO_DIV   = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            step_btn = 1'b0;
  logic            auto_mode = 1'b0;
  logic            prog_we = 1'b0;
  logic [PC_W-1:0] prog_addr = '0;
  logic [19:0]     prog_data = '0;
  logic [4:0]      R_Addr_A, R_Addr_B, W_Addr;
  logic [3:0]      ALU_OP;
  logic            Reg_Write, clk_RR, clk_F, clk_WB, busy;
  logic [PC_W-1:0] pc;

  regarray_step_ctrl #(
    .PROG_DEPTH (PROG_DEPTH),
    .PC_W       (PC_W),
    .DB_CYC     (DB_CYC),
    .AUTO_DIV   (AUTO_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_btn  (step_btn),
    .auto_mode (auto_mode),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .R_Addr_A  (R_Addr_A),
    .R_Addr_B  (R_Addr_B),
    .W_Addr    (W_Addr),
    .ALU_OP    (ALU_OP),
    .Reg_Write (Reg_Write),
    .clk_RR    (clk_RR),
    .clk_F     (clk_F),
    .clk_WB    (clk_WB),
    .busy      (busy),
    .pc        (pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [19:0] model_mem [PROG_DEPTH];
  always @(posedge clk) if (prog_we) model_mem[prog_addr] <= prog_data;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sequence model: FETCH at offset 0, RR/F/WB pulses at 1/3/5, IDLE at 7.
  bit          mon_en = 1'b0;
  int          pos = -1;
  int          model_pc = 0;
  int          seq_cnt = 0;
  int          last_end = -100;
  int          gap = 0;
  logic [19:0] exp_e = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pos < 0) begin
        chk("idle_pulses", {clk_RR, clk_F, clk_WB}, 3'b000);
        if (busy) begin
          pos   = 0;
          exp_e = model_mem[model_pc];
          gap   = cyc - last_end;
          chk("fetch_pc", pc, model_pc);
        end
      end else begin
        pos++;
        chk("seq_busy", busy, pos < 7);
        chk("seq_pulses", {clk_RR, clk_F, clk_WB}, {pos == 1, pos == 3, pos == 5});
        chk("seq_fields", {Reg_Write, ALU_OP, W_Addr, R_Addr_B, R_Addr_A}, exp_e);
        if (pos == 7) begin
          model_pc = (model_pc + 1) % PROG_DEPTH;
          chk("pc_incr", pc, model_pc);
          seq_cnt++;
          last_end = cyc;
          pos = -1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_entry(input logic [PC_W-1:0] a, input logic [19:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wait_seqs(input int target, input int budget);
    for (int i = 0; i < budget && seq_cnt < target; i++) @(negedge clk);
    chk("seq_count", seq_cnt, target);
  endtask

  task automatic wait_clk_f(input int budget);
    for (int i = 0; i < budget && clk_F !== 1'b1; i++) @(negedge clk);
    chk("clk_F_seen", clk_F, 1'b1);
  endtask

  task automatic press(input int hold, input int rel);
    step_btn = 1'b1; tick(hold);
    step_btn = 1'b0; tick(rel);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [19:0] e0, nv;
    int base, p0;

    // Reset with a chattering button.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      step_btn = ~step_btn;
      chk("rst_outputs", {R_Addr_A, R_Addr_B, W_Addr, ALU_OP, Reg_Write,
                          clk_RR, clk_F, clk_WB, busy, pc}, 0);
    end
    step_btn = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);

    e0 = {1'b1, 4'd1, 5'd2, 5'd2, 5'd3};
    write_entry(0, e0);
    for (int i = 1; i < PROG_DEPTH; i++) begin
      nv = 20'($urandom);
      write_entry(PC_W'(i), nv);
    end

    // Abort during F_H.
    step_btn = 1'b1;
    wait_clk_f(40);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_clk_F", clk_F, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_pc", pc, 0);
    chk("abort_fields", {Reg_Write, ALU_OP, W_Addr, R_Addr_B, R_Addr_A}, 0);
    step_btn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_wb", clk_WB, 1'b0);
    end
    rst_n = 1'b1;
    tick(12);
    chk("abort_idle", {busy, pc}, 0);

    // Clean step of entry 0.
    pos = -1; model_pc = 0; mon_en = 1'b1;
    press(8, 12);
    wait_seqs(1, 30);
    chk("step_A", R_Addr_A, 3);
    chk("step_B", R_Addr_B, 2);
    chk("step_W", W_Addr, 2);
    chk("step_OP", ALU_OP, 1);
    chk("step_RW", Reg_Write, 1'b1);
    chk("step_pc", pc, 1);
    chk("step_busy", busy, 1'b0);

    // Bouncing button: one sequence only.
    base = seq_cnt; p0 = int'(pc);
    for (int i = 0; i < 10; i++) begin
      step_btn = ~step_btn;
      tick(2);
    end
    press(14, 14);
    wait_seqs(base + 1, 10);
    chk("bounce_pc", pc, (p0 + 1) % PROG_DEPTH);

    // Fastest legal double press: next FETCH after a single IDLE cycle.
    base = seq_cnt; p0 = int'(pc);
    step_btn = 1'b1; tick(4);
    step_btn = 1'b0; tick(4);
    press(20, 12);
    wait_seqs(base + 2, 20);
    chk("b2b_gap", gap, 1);
    chk("b2b_pc", pc, (p0 + 2) % PROG_DEPTH);

    // Overwrite the next slot while the current entry is executing.
    base = seq_cnt; p0 = int'(pc);
    nv = 20'($urandom);
    step_btn = 1'b1;
    wait_clk_f(40);
    prog_we = 1'b1; prog_addr = PC_W'(p0 + 1); prog_data = nv;
    @(negedge clk);
    prog_we = 1'b0;
    tick(10);
    step_btn = 1'b0;
    tick(12);
    wait_seqs(base + 1, 20);
    press(8, 12);
    wait_seqs(base + 2, 20);
    chk("wr_busy_next", {Reg_Write, ALU_OP, W_Addr, R_Addr_B, R_Addr_A}, nv);

    // Fresh random program, reset, then nine auto steps with button noise.
    for (int i = 0; i < PROG_DEPTH; i++) begin
      nv = 20'($urandom);
      write_entry(PC_W'(i), nv);
    end
    mon_en = 1'b0;
    rst_n = 1'b0; tick(2);
    rst_n = 1'b1; tick(4);
    pos = -1; model_pc = 0; mon_en = 1'b1;
    chk("auto_pc0", pc, 0);
    base = seq_cnt;
    auto_mode = 1'b1;
    for (int i = 0; i < 9 * AUTO_DIV + 5; i++) begin
      step_btn = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    step_btn = 1'b0;
    tick(10);
    auto_mode = 1'b0;
    chk("auto_seqs", seq_cnt, base + 9);
    chk("auto_pc", pc, 1);
    tick(20);
    chk("manual_quiet", seq_cnt, base + 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
